// File: rtl/ff_pkg.sv
// Shared types for the run-time configurable flip-flop bank.
// The optional change counter is enabled with FF_BANK_CHGCNT_EN.
package ff_pkg;

   localparam int FF_MODE_W = 2;

   typedef enum logic [FF_MODE_W-1:0] {
      FF_D  = 2'b00,
      FF_T  = 2'b01,
      FF_JK = 2'b10,
      FF_SR = 2'b11
   } ff_mode_t;

endpackage

// File: rtl/ff_bank_if.sv
// Control/data bundle for ff_bank; chg_cnt is present only with FF_BANK_CHGCNT_EN.
interface ff_bank_if
   import ff_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic                 en;
   logic                 mode_ld;
   logic [FF_MODE_W-1:0] mode_in;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 err_clr;
   logic [WIDTH-1:0]     q;
   logic [FF_MODE_W-1:0] mode;
   logic                 err;
   logic [WIDTH-1:0]     err_bits;
   logic                 busy;
`ifdef FF_BANK_CHGCNT_EN
   logic [15:0]          chg_cnt;
`endif

   modport master (
      output en, mode_ld, mode_in, a, b, err_clr,
      input  q, mode, err, err_bits, busy
`ifdef FF_BANK_CHGCNT_EN
      , input chg_cnt
`endif
   );

   modport slave (
      input  en, mode_ld, mode_in, a, b, err_clr,
      output q, mode, err, err_bits, busy
`ifdef FF_BANK_CHGCNT_EN
      , output chg_cnt
`endif
   );

endinterface

// File: rtl/ff_next_cell.sv
// One flip-flop channel: next state for the selected type plus illegal-SR detect.
module ff_next_cell
   import ff_pkg::*;
(
   input  ff_mode_t mode,
   input  logic     a,
   input  logic     b,
   input  logic     q,
   output logic     q_nxt,
   output logic     ill
);

   always_comb begin
      q_nxt = q;
      ill   = 1'b0;
      case (mode)
         FF_D: q_nxt = a;
         FF_T: q_nxt = q ^ a;
         FF_JK: begin
            case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   q_nxt = ~q;
               default: q_nxt = q;
            endcase
         end
         default: begin
            // S=R=1 holds the bit and only raises the flag
            case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   ill   = 1'b1;
               default: q_nxt = q;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/ff_bank.sv
// WIDTH-bit register bank with run-time selectable D/T/JK/SR behaviour and sticky SR error.
// FF_BANK_CHGCNT_EN adds a saturating count of edges on which q changed.
module ff_bank
   import ff_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic    clk,
   input  logic    rst_n,
   ff_bank_if.slave bus
);

   logic [WIDTH-1:0] q_q, q_d;
   ff_mode_t         mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] err_bits_q, err_bits_d;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] ill;
   logic             upd;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_next_cell u_cell (
         .mode  (mode_q),
         .a     (bus.a[i]),
         .b     (bus.b[i]),
         .q     (q_q[i]),
         .q_nxt (q_nxt[i]),
         .ill   (ill[i])
      );
   end

   // busy covers the edge after a mode load; a load during busy extends it
   assign upd = bus.en && !busy_q && !bus.mode_ld;

   always_comb begin
      mode_d     = bus.mode_ld ? ff_mode_t'(bus.mode_in) : mode_q;
      busy_d     = bus.mode_ld;
      q_d        = upd ? q_nxt : q_q;
      err_d      = bus.err_clr ? 1'b0 : err_q;
      err_bits_d = bus.err_clr ? '0 : err_bits_q;
      if (upd) begin
         err_bits_d = err_bits_d | ill;
         if (|ill) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q        <= RST_VAL;
         mode_q     <= FF_D;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         err_bits_q <= '0;
      end else begin
         q_q        <= q_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         err_bits_q <= err_bits_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.mode     = mode_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
   assign bus.err_bits = err_bits_q;

`ifdef FF_BANK_CHGCNT_EN
   logic [15:0] chg_cnt_q, chg_cnt_d;

   always_comb begin
      chg_cnt_d = chg_cnt_q;
      if (bus.err_clr)
         chg_cnt_d = '0;
      else if ((q_d != q_q) && (chg_cnt_q != 16'hFFFF))
         chg_cnt_d = chg_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chg_cnt_q <= '0;
      else        chg_cnt_q <= chg_cnt_d;
   end

   assign bus.chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank (WIDTH=8, RST_VAL=0).
module tb_ff_bank;
   import ff_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   ff_bank_if #(.WIDTH(8)) bus ();

   ff_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] a, input logic [7:0] b, input logic clr);
      bus.en      = en;
      bus.a       = a;
      bus.b       = b;
      bus.err_clr = clr;
   endtask

   task automatic load_mode(input logic [1:0] m);
      bus.mode_ld = 1'b1;
      bus.mode_in = m;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      bus.mode_ld = 1'b0;
      bus.mode_in = 2'b00;
      drive(1'b0, 8'h00, 8'h00, 1'b0);

      // asynchronous reset mid-cycle
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_q", bus.q, 8'h00);
      check("rst_mode", bus.mode, 2'b00);
      check("rst_err", bus.err, 1'b0);
      check("rst_err_bits", bus.err_bits, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
`ifdef FF_BANK_CHGCNT_EN
      check("rst_chg_cnt", bus.chg_cnt, 16'h0000);
`endif
      tick();
      rst_n = 1'b1;

      // D mode
      drive(1'b1, 8'hA5, 8'h00, 1'b0);
      tick();
      check("d_load", bus.q, 8'hA5);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      check("d_en0_hold", bus.q, 8'hA5);

      // mode load to JK with bubble
      load_mode(FF_JK);
      drive(1'b1, 8'hF0, 8'h0F, 1'b0);
      tick();
      check("jk_ld_busy", bus.busy, 1'b1);
      check("jk_ld_mode", bus.mode, 2'b10);
      check("jk_ld_q_hold1", bus.q, 8'hA5);
      bus.mode_ld = 1'b0;
      tick();
      check("jk_bubble_busy", bus.busy, 1'b0);
      check("jk_bubble_q_hold2", bus.q, 8'hA5);
      tick();
      check("jk_set_clr", bus.q, 8'hF0);
      tick();
      check("jk_set_clr_again", bus.q, 8'hF0);

      // JK toggle
      drive(1'b1, 8'h3C, 8'hC3, 1'b0);
      tick();
      check("jk_to_3c", bus.q, 8'h3C);
      drive(1'b1, 8'hFF, 8'hFF, 1'b0);
      tick();
      check("jk_toggle1", bus.q, 8'hC3);
      tick();
      check("jk_toggle2", bus.q, 8'h3C);
      drive(1'b1, 8'h00, 8'h00, 1'b0);
      tick();
      check("jk_hold", bus.q, 8'h3C);

      // SR mode; illegal inputs during the bubble must not flag
      load_mode(FF_SR);
      drive(1'b1, 8'hFF, 8'hFF, 1'b0);
      tick();
      bus.mode_ld = 1'b0;
      tick();
      check("sr_bubble_no_err", bus.err, 1'b0);
      check("sr_bubble_q", bus.q, 8'h3C);
      drive(1'b1, 8'h01, 8'hFE, 1'b0);
      tick();
      check("sr_to_01", bus.q, 8'h01);
      drive(1'b1, 8'h81, 8'h01, 1'b0);
      tick();
      check("sr_ill_q", bus.q, 8'h81);
      check("sr_ill_err", bus.err, 1'b1);
      check("sr_ill_bits", bus.err_bits, 8'h01);
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      tick();
      check("sr_clr_err", bus.err, 1'b0);
      check("sr_clr_bits", bus.err_bits, 8'h00);
      drive(1'b1, 8'h02, 8'h02, 1'b1);
      tick();
      check("sr_clr_vs_ill_err", bus.err, 1'b1);
      check("sr_clr_vs_ill_bits", bus.err_bits, 8'h02);
      check("sr_clr_vs_ill_q", bus.q, 8'h81);

      // en=0 freezes error logic except err_clr
      drive(1'b0, 8'h00, 8'h00, 1'b1);
      tick();
      check("en0_clr_err", bus.err, 1'b0);
      drive(1'b0, 8'hFF, 8'hFF, 1'b0);
      tick();
      check("en0_no_err", bus.err, 1'b0);
      check("en0_q", bus.q, 8'h81);

      // back-to-back mode loads extend the bubble
      load_mode(FF_T);
      drive(1'b1, 8'h55, 8'h00, 1'b0);
      tick();
      load_mode(FF_D);
      tick();
      check("reload_busy", bus.busy, 1'b1);
      check("reload_mode", bus.mode, 2'b00);
      check("reload_q_hold", bus.q, 8'h81);
      bus.mode_ld = 1'b0;
      tick();
      check("reload_bubble_end", bus.busy, 1'b0);
      check("reload_bubble_q", bus.q, 8'h81);
      tick();
      check("reload_d_update", bus.q, 8'h55);

      // T mode
      load_mode(FF_T);
      drive(1'b1, 8'h0F, 8'h00, 1'b0);
      tick();
      bus.mode_ld = 1'b0;
      tick();
      tick();
      check("t_toggle", bus.q, 8'h5A);

      // reset mid-bubble cancels it
      load_mode(FF_JK);
      tick();
      bus.mode_ld = 1'b0;
      check("pre_rst_busy", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midbubble_rst_busy", bus.busy, 1'b0);
      check("midbubble_rst_mode", bus.mode, 2'b00);
      check("midbubble_rst_q", bus.q, 8'h00);
      drive(1'b1, 8'hC3, 8'h00, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_d_update", bus.q, 8'hC3);

`ifdef FF_BANK_CHGCNT_EN
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      tick();
      check("cnt_cleared", bus.chg_cnt, 16'h0000);
      load_mode(FF_T);
      drive(1'b1, 8'h01, 8'h00, 1'b0);
      tick();
      bus.mode_ld = 1'b0;
      tick();
      for (int i = 0; i < 70000; i++) tick();
      check("cnt_saturated", bus.chg_cnt, 16'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
